// File: rtl/wait_pulse_detect.sv
// Receive-side checker for the high/low/high wait pattern: measures each line
// segment against SEG +/- TOL and strobes detected or error.
module wait_pulse_detect #(
  parameter int unsigned SEG = 16384,
  parameter int unsigned TOL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        din,
  output logic        detected,
  output logic        error,
  output logic        busy,
  output logic [15:0] width
);
  // state | meaning
  // IDLE  | waiting for an enabled rising edge on din
  // HI1   | measuring the first high segment
  // GAP   | measuring the low gap between the pulses
  // HI2   | measuring the second high segment
  typedef enum logic [1:0] {IDLE, HI1, GAP, HI2} state_t;

  localparam logic [16:0] WIN_LO = 17'(SEG - TOL);
  localparam logic [16:0] WIN_HI = 17'(SEG + TOL);
  localparam logic [15:0] OVR_W  = 16'(SEG + TOL + 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] width_q, width_d;
  logic        din_q;
  logic        detected_q, detected_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_inc;
  logic        rise, fall, in_win, at_max, seg_end;

  assign rise    = din & ~din_q;
  assign fall    = ~din & din_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign in_win  = ({1'b0, cnt_q} >= WIN_LO) && ({1'b0, cnt_q} <= WIN_HI);
  // One more sample at the current level would push the count past the window.
  assign at_max  = ({1'b0, cnt_q} >= WIN_HI);
  assign seg_end = (state_q == GAP) ? rise : fall;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    detected_d = 1'b0;
    error_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = HI1;
            cnt_d   = 16'd1;
          end
        end
        HI1, GAP, HI2: begin
          if (seg_end) begin
            width_d = cnt_q;
            cnt_d   = 16'd1;
            if (!in_win) begin
              error_d = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else if (state_q == HI1) begin
              state_d = GAP;
            end else if (state_q == GAP) begin
              state_d = HI2;
            end else begin
              detected_d = 1'b1;
              state_d    = IDLE;
              cnt_d      = '0;
            end
          end else if (at_max) begin
            width_d = OVR_W;
            error_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      din_q      <= 1'b1;
      detected_q <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      din_q      <= din;
      detected_q <= detected_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  assign detected = detected_q;
  assign error    = error_q;
  assign busy     = busy_q;
  assign width    = width_q;
endmodule

// File: doc/wait_pulse_detect.md
# wait_pulse_detect

Receive-side checker for the fixed two-pulse wait pattern driven by the on-board wait counter. It samples the serial line, measures each high and low segment with a 16-bit saturating counter, and validates the sequence: high for SEG cycles, low for SEG cycles, high for SEG cycles, then low. On a match it emits a one-cycle `detected` strobe; any out-of-window segment gives a one-cycle `error` strobe. It sits at the far end of the wait line, in the same clock domain as the generator.

## Interface

Parameters:
- SEG, 16384: nominal segment length in clk cycles.
- TOL, 16: allowed deviation, ± cycles. Constraints: SEG > TOL and SEG+TOL ≤ 16'hFFFE.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low.
- enable  input  1  active-high arm; low forces IDLE.
- din  input  1  wait line, synchronous to clk; no internal synchronizer.
- detected  output  1  one-cycle strobe: valid pattern received.
- error  output  1  one-cycle strobe: pattern aborted.
- busy  output  1  high while the FSM is not in IDLE.
- width  output  16  length of the last completed or aborted segment.

## Operation

- All outputs are registered. Reset values: detected=0, error=0, busy=0, width=0, cnt=0, state=IDLE, din_q=1.
- din_q is din delayed one cycle. It resets to 1, so a line held high through reset does not give a false rising edge.
- rise = din & ~din_q; fall = ~din & din_q.
- Window check: in-window means SEG-TOL ≤ cnt ≤ SEG+TOL. Bounds are elaboration constants. Comparisons are 17-bit unsigned.
- cnt saturates at 16'hFFFF and never wraps.
- FSM states and transitions:
  - IDLE: when enable & rise, go to HI1 and set cnt=1.
  - HI1: while din=1, cnt++. On fall: width←cnt; if in-window go to GAP with cnt=1, else error and go to IDLE.
  - GAP: while din=0, cnt++. On rise: width←cnt; if in-window go to HI2 with cnt=1, else error and go to IDLE.
  - HI2: while din=1, cnt++. On fall: width←cnt; if in-window, pulse detected, else pulse error. Go to IDLE in both cases.
- Overrun: in HI1, GAP or HI2, if the increment would make cnt exceed SEG+TOL, abort at once. width←SEG+TOL+1, error pulses, go to IDLE. The bench does not wait for the edge.
- After an abort or a completion, IDLE needs a fresh rise. A line still high after an HI1 overrun is ignored until it goes low and then high again.
- enable=0 in any state: go to IDLE and clear cnt. No strobe is produced. width holds its value.
- enable falling in the same cycle as a completing edge: enable wins, and neither strobe fires.
- detected and error are mutually exclusive and never high two cycles in a row.
- Reset mid-operation returns everything to the reset values on that edge.

## Timing

- Segment length rule: a segment is counted from the edge sample where the new level is first seen (cnt=1) to the last sample at that level. A generator pulse of exactly N high cycles gives cnt=N.
- Completion latency: detected and error are high in the cycle after the clock edge that first samples din low (end of HI2), or that samples the bad edge. width updates on that same edge.
- Overrun latency: error is high in the cycle after the edge where cnt would reach SEG+TOL+1.
- busy rises in the cycle after the starting rise. It falls together with the detected or error strobe.
- Back-to-back patterns: a new rise one cycle after the HI2 fall is accepted. The minimum inter-pattern low time is 1 cycle.

## Test plan

- **Nominal pattern** (SEG=16384, TOL=16): din high 16384, low 16384, high 16384, then low. Required: exactly one detected pulse, one cycle after the final fall; width=16384; error never asserted.
- **Window edges**:
  - high 16368, low 16400, high 16400: detected.
  - Repeat with first high 16367: error one cycle after the first fall, width=16367, busy=0 afterwards, no detected.
- **Overrun**: a rise, then din stuck high. Required: error when cnt would reach 16401, width=16401, state IDLE. Dropping din and raising it again restarts HI1.
- **Reset mid-GAP**: assert reset (0) for one cycle at GAP cnt=5000, with din held high across the reset release. Required: all outputs 0 the next cycle; no HI1 entry until din goes 0 then 1.
- **Enable abort**: enable driven 0 during HI2 at cnt=100. Required: busy=0 the next cycle; no detected or error; width retains the GAP length.
- **Back-to-back**: two nominal patterns separated by 1 low cycle. Required: two detected pulses, 49153 cycles apart.
